// File: rtl/alu_pipe_if.sv
// Handshake and data bundle for alu_pipe: operand beat in, result beat plus flags out.
// The master modport is the operand sequencer / writeback side; slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             oe;
    logic [WIDTH-1:0] y;
    logic             parity;
    logic             overflow;
    logic             greater;
    logic             is_eq;
    logic             less;
    logic             ovf_sticky;
    logic             ovf_clr;

    modport master (
        output in_valid, a, b, op, out_ready, oe, ovf_clr,
        input  in_ready, out_valid, y, parity, overflow, greater, is_eq, less, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, op, out_ready, oe, ovf_clr,
        output in_ready, out_valid, y, parity, overflow, greater, is_eq, less, ovf_sticky
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, status flags and a sticky overflow bit.
// Optional feature: define ALU_PIPE_SAT_EN to saturate ADD/SUB on signed overflow.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_OR   = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    // Stage 1: captured operands
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    op_t              s1_op_reg;

    // Stage 2: result and flags presented on the output
    logic             s2_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             parity_reg;
    logic             overflow_reg;
    logic             greater_reg;
    logic             is_eq_reg;
    logic             less_reg;
    logic             ovf_sticky_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             deliver;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             shift_ok;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic [WIDTH-1:0] par_chain;

    assign s2_adv  = !s2_valid_reg || bus.out_ready;
    assign s1_adv  = !s1_valid_reg || s2_adv;
    assign accept  = bus.in_valid && s1_adv;
    assign deliver = s2_valid_reg && bus.out_ready;

    assign sum      = s1_a_reg + s1_b_reg;
    assign diff     = s1_a_reg - s1_b_reg;
    assign shamt    = s1_b_reg[SHW-1:0];
    assign shift_ok = (32'(shamt) < 32'(WIDTH));

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                result_next   = sum;
                overflow_next = (s1_a_reg[MSB] == s1_b_reg[MSB]) && (sum[MSB] != s1_a_reg[MSB]);
            end
            OP_SUB: begin
                result_next   = diff;
                overflow_next = (s1_a_reg[MSB] != s1_b_reg[MSB]) && (diff[MSB] != s1_a_reg[MSB]);
            end
            OP_AND:  result_next = s1_a_reg & s1_b_reg;
            OP_XOR:  result_next = s1_a_reg ^ s1_b_reg;
            OP_OR:   result_next = s1_a_reg | s1_b_reg;
            OP_SHL:  result_next = shift_ok ? (s1_a_reg << shamt) : '0;
            OP_SHR:  result_next = shift_ok ? (s1_a_reg >> shamt) : '0;
            OP_PASS: result_next = s1_a_reg;
            default: result_next = '0;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction always follows the sign of a for both ADD and SUB
        if (overflow_next) begin
            result_next = s1_a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
    end

    assign par_chain[0] = result_next[0];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_parity
            assign par_chain[gi] = par_chain[gi-1] ^ result_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (accept) begin
                s1_a_reg  <= bus.a;
                s1_b_reg  <= bus.b;
                s1_op_reg <= op_t'(bus.op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            result_reg   <= '0;
            parity_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            greater_reg  <= 1'b0;
            is_eq_reg    <= 1'b0;
            less_reg     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg   <= result_next;
                parity_reg   <= par_chain[WIDTH-1];
                overflow_reg <= overflow_next;
                greater_reg  <= s1_a_reg > s1_b_reg;
                is_eq_reg    <= s1_a_reg == s1_b_reg;
                less_reg     <= s1_a_reg < s1_b_reg;
            end
        end
    end

    // Clear has priority over a set arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_reg <= 1'b0;
        end else if (bus.ovf_clr) begin
            ovf_sticky_reg <= 1'b0;
        end else if (deliver && overflow_reg) begin
            ovf_sticky_reg <= 1'b1;
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid_reg;
    assign bus.y          = bus.oe ? result_reg : '0;
    assign bus.parity     = parity_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.greater    = greater_reg;
    assign bus.is_eq      = is_eq_reg;
    assign bus.less       = less_reg;
    assign bus.ovf_sticky = ovf_sticky_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed cases, a random stalled stream
// against an arithmetic reference model, sticky overflow handling and mid-stream reset.
module tb_alu_pipe;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       ovf;
        logic       gt;
        logic       eq;
        logic       lt;
        logic       par;
    } exp_t;

    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
        exp_t e;
        int   sa;
        int   sb;
        int   r;
        int   sh;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sh = int'(mb) % 8;
        e  = '0;
        case (mop)
            3'd0, 3'd1: begin
                r = (mop == 3'd0) ? sa + sb : sa - sb;
                e.ovf = (r > 127) || (r < -128);
                e.y = r[7:0];
`ifdef ALU_PIPE_SAT_EN
                if (r > 127) e.y = 8'h7F;
                if (r < -128) e.y = 8'h80;
`endif
            end
            3'd2: e.y = ma & mb;
            3'd3: e.y = ma ^ mb;
            3'd4: e.y = ma | mb;
            3'd5: begin
                r = (int'(ma) * (1 << sh)) % 256;
                e.y = r[7:0];
            end
            3'd6: begin
                r = int'(ma) / (1 << sh);
                e.y = r[7:0];
            end
            default: e.y = ma;
        endcase
        e.gt  = int'(ma) > int'(mb);
        e.eq  = int'(ma) == int'(mb);
        e.lt  = int'(ma) < int'(mb);
        e.par = ($countones(e.y) % 2) == 1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.y   = bus.y;
        o.ovf = bus.overflow;
        o.gt  = bus.greater;
        o.eq  = bus.is_eq;
        o.lt  = bus.less;
        o.par = bus.parity;
        return o;
    endfunction

    // Send one beat into an empty pipe and check latency plus the full result at the output.
    task automatic directed(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                            input string tag);
        exp_t e;
        e = model(ta, tb_v, top);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.op        = top;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'(1'b0));
        @(negedge clk);
        #1;
        check({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'(1'b1));
        check({tag, "_result"}, 32'(observed()), 32'(e));
        $display("directed %s a=%02h b=%02h op=%0d y=%02h ovf=%0b", tag, ta, tb_v, top, bus.y, bus.overflow);
    endtask

    exp_t q[$];
    exp_t e_front;
    exp_t held;
    logic held_valid;
    logic have_beat;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [2:0] rop;
    int   n_sent;
    int   n_recv;
    int   inflight;
    int   cyc;
    logic fire_in;
    logic fire_out;
    logic [3:0] ready_pat;

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        bus.oe        = 1'b1;
        bus.ovf_clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
        check("rst_y", 32'(bus.y), 32'(0));
        check("rst_sticky", 32'(bus.ovf_sticky), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("idle_in_ready", 32'(bus.in_ready), 32'(1'b1));

        // Signed overflow on ADD, then sticky set after delivery
        directed(8'h7F, 8'h01, 3'd0, "add_ovf");
        @(negedge clk);
        #1;
        check("sticky_set", 32'(bus.ovf_sticky), 32'(1'b1));

        // Equal SUB, then output enable gating only y
        directed(8'h10, 8'h10, 3'd1, "sub_eq");
        bus.oe = 1'b0;
        #1;
        check("oe0_y", 32'(bus.y), 32'(0));
        check("oe0_parity", 32'(bus.parity), 32'(1'b0));
        check("oe0_is_eq", 32'(bus.is_eq), 32'(1'b1));
        @(negedge clk);
        bus.oe = 1'b1;

        directed(8'h03, 8'h05, 3'd5, "shl");
        directed(8'h80, 8'h07, 3'd6, "shr");
        directed(8'hA5, 8'h3C, 3'd7, "pass");
        directed(8'h80, 8'h01, 3'd1, "sub_ovf");
        directed(8'h0F, 8'hF0, 3'd3, "xor_lt");

        // Clear arriving together with another overflow delivery wins
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h80;
        bus.b         = 8'h80;
        bus.op        = 3'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("clr_pre_valid", 32'(bus.out_valid), 32'(1'b1));
        check("clr_pre_ovf", 32'(bus.overflow), 32'(1'b1));
        check("clr_pre_sticky", 32'(bus.ovf_sticky), 32'(1'b1));
        bus.ovf_clr   = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        #1;
        check("clr_wins_sticky", 32'(bus.ovf_sticky), 32'(1'b0));
        $display("sticky clear with simultaneous overflow delivery: sticky=%0b", bus.ovf_sticky);

        // Random back-to-back stream with out_ready pattern 1-0-0-1
        ready_pat  = 4'b1001;
        n_sent     = 0;
        n_recv     = 0;
        inflight   = 0;
        cyc        = 0;
        held_valid = 1'b0;
        have_beat  = 1'b0;
        while (n_recv < 16 && cyc < 300) begin
            @(negedge clk);
            if (!have_beat && n_sent < 16) begin
                ra        = 8'($urandom);
                rb        = 8'($urandom);
                rop       = 3'($urandom_range(0, 7));
                have_beat = 1'b1;
            end
            bus.in_valid  = have_beat;
            bus.a         = ra;
            bus.b         = rb;
            bus.op        = rop;
            bus.out_ready = ready_pat[cyc % 4];
            #1;
            check("rnd_in_ready", 32'(bus.in_ready), 32'(!(inflight == 2 && !bus.out_ready)));
            if (held_valid) begin
                check("rnd_stall_valid", 32'(bus.out_valid), 32'(1'b1));
                check("rnd_stall_stable", 32'(observed()), 32'(held));
            end
            fire_in  = have_beat && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                check("rnd_valid_has_beat", 32'(q.size() > 0), 32'(1'b1));
            end
            if (fire_out && q.size() > 0) begin
                e_front = q.pop_front();
                check("rnd_result", 32'(observed()), 32'(e_front));
                $display("rnd beat %0d y=%02h flags=%05b", n_recv, bus.y, observed() & 13'h1F);
                n_recv++;
                inflight--;
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held       = observed();
            if (fire_in) begin
                q.push_back(model(ra, rb, rop));
                n_sent++;
                inflight++;
                have_beat = 1'b0;
            end
            cyc++;
        end
        check("rnd_all_delivered", 32'(n_recv), 32'(16));
        bus.in_valid = 1'b0;

        // Reset with two beats in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
        bus.op        = 3'd0;
        @(negedge clk);
        bus.a = 8'h33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("inflight_valid", 32'(bus.out_valid), 32'(1'b1));
        check("inflight_full_ready", 32'(bus.in_ready), 32'(1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("midrst_y", 32'(bus.y), 32'(0));
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("postrst_no_beat", 32'(bus.out_valid), 32'(1'b0));
        end
        $display("mid-stream reset: no beat emerged");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
